// File: rtl/ped_pass_req.sv
// Pedestrian pass-request generator: synchronises and debounces the push-button,
// holds a request until a clean green phase, and enforces a cooldown after each pass.
module ped_pass_req #(
  parameter int DEB_CYC  = 4,
  parameter int COOLDOWN = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  input  logic       R,
  input  logic       G,
  input  logic       Y,
  output logic       pass,
  output logic       req_pending,
  output logic       cool_busy,
  output logic       light_err,
  output logic [7:0] pass_cnt
);

  localparam int DW = $clog2(DEB_CYC + 1);
  localparam int CW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam logic [DW-1:0] DCNT_LAST = DW'(DEB_CYC - 1);
  localparam logic [CW-1:0] COOL_LOAD = CW'(COOLDOWN - 1);

  typedef enum logic [1:0] {IDLE, PEND, FIRE, COOL} state_e;

  logic          s1_q, s2_q;
  logic          db_q, db_d1_q;
  logic [DW-1:0] dcnt_q;
  logic          light_err_q;
  logic          rise;
  logic [2:0]    rgy;
  logic          light_ok;

  state_e        state_q, state_d;
  logic [CW-1:0] cool_cnt_q, cool_cnt_d;
  logic          again_q, again_d;
  logic [7:0]    pass_cnt_q, pass_cnt_d;

  assign rgy      = {R, G, Y};
  assign light_ok = (rgy == 3'b100) || (rgy == 3'b010) || (rgy == 3'b001);
  assign rise     = db_q & ~db_d1_q;

  // Front end: two-flop synchroniser, debounce counter, edge history, light check.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      db_q        <= 1'b0;
      db_d1_q     <= 1'b0;
      dcnt_q      <= '0;
      light_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of its neighbour.
      s1_q        <= btn;
      s2_q        <= s1_q;
      db_d1_q     <= db_q;
      light_err_q <= ~light_ok;
      if (s2_q != db_q) begin
        if (dcnt_q == DCNT_LAST) begin
          db_q   <= s2_q;
          dcnt_q <= '0;
        end else begin
          dcnt_q <= dcnt_q + 1'b1;
        end
      end else begin
        dcnt_q <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cool_cnt_q <= '0;
      again_q    <= 1'b0;
      pass_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cool_cnt_q <= cool_cnt_d;
      again_q    <= again_d;
      pass_cnt_q <= pass_cnt_d;
    end
  end

  always_comb begin
    // NOTE: hold-value defaults first so no path through the case infers a latch.
    state_d    = state_q;
    cool_cnt_d = cool_cnt_q;
    again_d    = again_q;
    pass_cnt_d = pass_cnt_q;
    unique case (state_q)
      IDLE: if (rise) state_d = PEND;
      // Extra rises while pending merge into the one outstanding request.
      PEND: if (rgy == 3'b010) state_d = FIRE;
      FIRE: begin
        state_d    = COOL;
        cool_cnt_d = COOL_LOAD;
        if (pass_cnt_q != 8'hFF) pass_cnt_d = pass_cnt_q + 8'd1;
      end
      COOL: begin
        if (cool_cnt_q == '0) begin
          state_d = (again_q || rise) ? PEND : IDLE;
          again_d = 1'b0;
        end else begin
          cool_cnt_d = cool_cnt_q - 1'b1;
          if (rise) again_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pass        = (state_q == FIRE);
  assign req_pending = (state_q == PEND);
  assign cool_busy   = (state_q == COOL);
  assign light_err   = light_err_q;
  assign pass_cnt    = pass_cnt_q;

endmodule

// File: tb/tb_ped_pass_req.sv
// Directed self-checking bench for ped_pass_req at default parameters
// (DEB_CYC=4, COOLDOWN=16); inputs change and outputs are sampled on the falling edge.
module tb_ped_pass_req;

  logic       clk;
  logic       rst;
  logic       btn;
  logic       R, G, Y;
  logic       pass, req_pending, cool_busy, light_err;
  logic [7:0] pass_cnt;

  int checks   = 0;
  int failures = 0;
  int pass_seen = 0;

  ped_pass_req dut (
    .clk         (clk),
    .rst         (rst),
    .btn         (btn),
    .R           (R),
    .G           (G),
    .Y           (Y),
    .pass        (pass),
    .req_pending (req_pending),
    .cool_busy   (cool_busy),
    .light_err   (light_err),
    .pass_cnt    (pass_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (pass) pass_seen <= pass_seen + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_light(input logic [2:0] rgy);
    {R, G, Y} = rgy;
  endtask

  int  base;
  logic rp_any;

  initial begin
    rst = 1'b0;
    btn = 1'b0;
    set_light(3'b010);
    #12;
    check("rst_pass", pass, 0);
    check("rst_pending", req_pending, 0);
    check("rst_cool", cool_busy, 0);
    check("rst_lerr", light_err, 0);
    check("rst_cnt", pass_cnt, 0);
    @(negedge clk);
    rst = 1'b1;
    tick(2);

    // Glitch of three samples is rejected by the debouncer.
    btn = 1'b1;
    tick(3);
    btn = 1'b0;
    rp_any = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      rp_any = rp_any | req_pending | pass;
    end
    check("glitch_no_req", rp_any, 0);
    check("glitch_cnt", pass_cnt, 0);

    // Press during green held for 20 cycles.
    base = pass_seen;
    btn = 1'b1;
    tick(6);
    check("green_pend_early", req_pending, 0);
    tick(1);
    check("green_pend", req_pending, 1);
    check("green_no_pass_yet", pass, 0);
    tick(1);
    check("green_pass", pass, 1);
    check("green_cnt_before", pass_cnt, 0);
    tick(1);
    check("green_pass_fall", pass, 0);
    check("green_cool_start", cool_busy, 1);
    check("green_cnt_after", pass_cnt, 1);
    tick(11);
    btn = 1'b0;
    tick(4);
    check("green_cool_last", cool_busy, 1);
    tick(1);
    check("green_cool_end", cool_busy, 0);
    check("green_idle", req_pending, 0);
    tick(20);
    check("green_single_pass", pass_seen - base, 1);
    check("green_cnt_final", pass_cnt, 1);

    // Press during red waits, then fires when green appears.
    set_light(3'b100);
    btn = 1'b1;
    tick(7);
    check("red_pend", req_pending, 1);
    tick(10);
    check("red_still_pend", req_pending, 1);
    check("red_no_pass", pass, 0);
    check("red_lerr_clean", light_err, 0);
    set_light(3'b010);
    tick(1);
    check("red_then_green_pass", pass, 1);
    tick(1);
    check("red_cnt", pass_cnt, 2);
    btn = 1'b0;
    tick(25);

    // Second press during cooldown re-enters PEND directly on expiry.
    base = pass_seen;
    btn = 1'b1;
    tick(7);
    btn = 1'b0;
    tick(1);
    check("again_pass1", pass, 1);
    tick(1);
    check("again_cool", cool_busy, 1);
    check("again_cnt1", pass_cnt, 3);
    tick(6);
    btn = 1'b1;
    tick(9);
    check("again_cool_last", cool_busy, 1);
    check("again_not_pend_yet", req_pending, 0);
    tick(1);
    check("again_pend_on_expiry", req_pending, 1);
    check("again_cool_done", cool_busy, 0);
    tick(1);
    check("again_pass2", pass, 1);
    tick(1);
    check("again_cnt2", pass_cnt, 4);
    check("again_two_passes", pass_seen - base, 2);
    btn = 1'b0;
    tick(25);

    // Illegal light code blocks firing and raises light_err.
    set_light(3'b100);
    btn = 1'b1;
    tick(7);
    check("ill_pend", req_pending, 1);
    check("ill_lerr_before", light_err, 0);
    set_light(3'b110);
    tick(1);
    check("ill_lerr", light_err, 1);
    check("ill_no_pass", pass, 0);
    set_light(3'b000);
    tick(3);
    check("ill_lerr_dark", light_err, 1);
    check("ill_still_pend", req_pending, 1);
    set_light(3'b010);
    tick(1);
    check("ill_lerr_clear", light_err, 0);
    check("ill_pass", pass, 1);
    tick(1);
    check("ill_cnt", pass_cnt, 5);

    // Asynchronous reset in the middle of COOL.
    tick(3);
    check("mid_cool", cool_busy, 1);
    #2;
    rst = 1'b0;
    btn = 1'b0;
    #1;
    check("arst_cool", cool_busy, 0);
    check("arst_cnt", pass_cnt, 0);
    check("arst_pass", pass, 0);
    check("arst_pend", req_pending, 0);
    @(negedge clk);
    rst = 1'b1;
    tick(3);

    // 260 passes; the counter saturates at 255 while pulses continue.
    base = pass_seen;
    for (int i = 0; i < 260; i++) begin
      btn = 1'b1;
      tick(7);
      btn = 1'b0;
      tick(23);
      if (i == 254) check("sat_reach", pass_cnt, 255);
    end
    check("sat_cnt", pass_cnt, 255);
    check("sat_pulses", pass_seen - base, 260);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
